alu_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared, registered-output ALU. The ALU latches its result on the clock edge, so the arbiter owns it and serialises requests from two clients: port A (core execute stage) and port B (auxiliary unit, e.g. address/branch compare). It grants one request at a time with round-robin fairness and drives the ALU operand/opcode lines. It then captures the ALU result and returns it to the owning port with a valid/ready handshake.

---
 rtl/alu_arbiter.sv | 155 +++++++++++++++
 tb/tb_alu_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter and sequencer for a shared registered-output ALU.
// One operation in flight: accept -> issue -> wait for ALU -> hold response until consumed.
module alu_arbiter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,

  input  logic             a_req_valid,
  output logic             a_req_ready,
  input  logic [3:0]       a_req_ctr,
  input  logic [31:0]      a_req_srcA,
  input  logic [31:0]      a_req_srcB,
  output logic             a_resp_valid,
  input  logic             a_resp_ready,
  output logic [31:0]      a_resp_data,

  input  logic             b_req_valid,
  output logic             b_req_ready,
  input  logic [3:0]       b_req_ctr,
  input  logic [31:0]      b_req_srcA,
  input  logic [31:0]      b_req_srcB,
  output logic             b_resp_valid,
  input  logic             b_resp_ready,
  output logic [31:0]      b_resp_data,

  output logic [3:0]       alu_ctr,
  output logic [31:0]      alu_srcA,
  output logic [31:0]      alu_srcB,
  input  logic [31:0]      alu_resp,

  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTR_W  = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [CTR_W-1:0]  ctr_q, ctr_d;
  logic [DATA_W-1:0] src_a_q, src_a_d;
  logic [DATA_W-1:0] src_b_q, src_b_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [CNT_W-1:0]  ops_done_q, ops_done_d;

  logic idle_c;
  logic grant_b_c;
  logic a_accept_c;
  logic b_accept_c;
  logic owner_ready_c;

  // Round-robin pick: B wins alone, or on contention when A had the last grant.
  always_comb begin
    idle_c        = resetn && (state_q == S_IDLE);
    grant_b_c     = b_req_valid && (!a_req_valid || (last_grant_q == PORT_A));
    a_accept_c    = idle_c && a_req_valid && !grant_b_c;
    b_accept_c    = idle_c && grant_b_c;
    owner_ready_c = (owner_q == PORT_B) ? b_resp_ready : a_resp_ready;
  end

  assign a_req_ready = a_accept_c;
  assign b_req_ready = b_accept_c;

  // Next-state and datapath update
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    ctr_d        = ctr_q;
    src_a_d      = src_a_q;
    src_b_d      = src_b_q;
    result_d     = result_q;
    ops_done_d   = ops_done_q;

    case (state_q)
      S_IDLE: begin
        if (b_accept_c) begin
          owner_d      = PORT_B;
          last_grant_d = PORT_B;
          ctr_d        = b_req_ctr;
          src_a_d      = b_req_srcA;
          src_b_d      = b_req_srcB;
          state_d      = S_ISSUE;
        end else if (a_accept_c) begin
          owner_d      = PORT_A;
          last_grant_d = PORT_A;
          ctr_d        = a_req_ctr;
          src_a_d      = a_req_srcA;
          src_b_d      = a_req_srcB;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        result_d = alu_resp;
        state_d  = S_RESP;
      end
      S_RESP: begin
        if (owner_ready_c) begin
          ops_done_d = ops_done_q + CNT_W'(1);
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      owner_q      <= PORT_A;
      last_grant_q <= PORT_B;
      ctr_q        <= '0;
      src_a_q      <= '0;
      src_b_q      <= '0;
      result_q     <= '0;
      ops_done_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      ctr_q        <= ctr_d;
      src_a_q      <= src_a_d;
      src_b_q      <= src_b_d;
      result_q     <= result_d;
      ops_done_q   <= ops_done_d;
    end
  end

  assign alu_ctr      = ctr_q;
  assign alu_srcA     = src_a_q;
  assign alu_srcB     = src_b_q;
  assign busy         = (state_q != S_IDLE);
  assign ops_done     = ops_done_q;
  assign a_resp_valid = (state_q == S_RESP) && (owner_q == PORT_A);
  assign b_resp_valid = (state_q == S_RESP) && (owner_q == PORT_B);
  // Both ports see the captured result; only the owner's valid qualifies it.
  assign a_resp_data  = result_q;
  assign b_resp_data  = result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural registered ALU (CNT_W=2 to exercise wrap).
module tb_alu_arbiter;

  localparam int unsigned CNT_W = 2;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLT = 4'd5;

  logic clk = 1'b0;
  logic resetn;
  logic a_req_valid, a_req_ready, a_resp_valid, a_resp_ready;
  logic [3:0] a_req_ctr;
  logic [31:0] a_req_srcA, a_req_srcB, a_resp_data;
  logic b_req_valid, b_req_ready, b_resp_valid, b_resp_ready;
  logic [3:0] b_req_ctr;
  logic [31:0] b_req_srcA, b_req_srcB, b_resp_data;
  logic [3:0] alu_ctr;
  logic [31:0] alu_srcA, alu_srcB, alu_resp;
  logic busy;
  logic [CNT_W-1:0] ops_done;

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.CNT_W(CNT_W)) u_dut (
    .clk(clk), .resetn(resetn),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_ctr(a_req_ctr),
    .a_req_srcA(a_req_srcA), .a_req_srcB(a_req_srcB),
    .a_resp_valid(a_resp_valid), .a_resp_ready(a_resp_ready), .a_resp_data(a_resp_data),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_ctr(b_req_ctr),
    .b_req_srcA(b_req_srcA), .b_req_srcB(b_req_srcB),
    .b_resp_valid(b_resp_valid), .b_resp_ready(b_resp_ready), .b_resp_data(b_resp_data),
    .alu_ctr(alu_ctr), .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_resp(alu_resp),
    .busy(busy), .ops_done(ops_done)
  );

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    case (op)
      OP_ADD:  return x + y;
      OP_SUB:  return x - y;
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_XOR:  return x ^ y;
      OP_SLT:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Registered ALU: result appears one edge after operands are sampled
  always_ff @(posedge clk) alu_resp <= alu_f(alu_ctr, alu_srcA, alu_srcB);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    a_req_valid = 1'b1; a_req_ctr = OP_ADD; a_req_srcA = 32'd0; a_req_srcB = 32'd0; a_resp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_ctr = OP_ADD; b_req_srcA = 32'd0; b_req_srcB = 32'd0; b_resp_ready = 1'b0;
    step(); step();
    // Reset state, with A valid showing ready gated low in reset
    chk("rst_a_ready", 32'(a_req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ops", 32'(ops_done), 32'd0);
    chk("rst_alu_ctr", 32'(alu_ctr), 32'd0);
    chk("rst_alu_srcA", alu_srcA, 32'd0);
    chk("rst_alu_srcB", alu_srcB, 32'd0);
    chk("rst_a_resp_valid", 32'(a_resp_valid), 32'd0);
    chk("rst_b_resp_valid", 32'(b_resp_valid), 32'd0);
    a_req_valid = 1'b0;
    resetn = 1'b1;
    step();

    // Single A: ADD 5+7
    a_req_valid = 1'b1; a_req_ctr = OP_ADD; a_req_srcA = 32'd5; a_req_srcB = 32'd7; a_resp_ready = 1'b1;
    #1;
    chk("t1_a_ready", 32'(a_req_ready), 32'd1);
    chk("t1_b_ready", 32'(b_req_ready), 32'd0);
    step();
    a_req_valid = 1'b0;
    chk("t1_busy_issue", 32'(busy), 32'd1);
    chk("t1_alu_srcA", alu_srcA, 32'd5);
    chk("t1_alu_srcB", alu_srcB, 32'd7);
    step();
    chk("t1_resp_early", 32'(a_resp_valid), 32'd0);
    step();
    chk("t1_a_resp_valid", 32'(a_resp_valid), 32'd1);
    chk("t1_a_resp_data", a_resp_data, 32'd12);
    chk("t1_b_resp_valid", 32'(b_resp_valid), 32'd0);
    chk("t1_ops_pre", 32'(ops_done), 32'd0);
    step();
    chk("t1_ops", 32'(ops_done), 32'd1);
    chk("t1_idle", 32'(busy), 32'd0);
    chk("t1_alu_hold", alu_srcA, 32'd5);

    // Contention from reset: 8 alternating ops, counter wraps at 4
    resetn = 1'b0;
    #1;
    chk("t2_rst_ops", 32'(ops_done), 32'd0);
    resetn = 1'b1;
    a_req_valid = 1'b1; a_req_ctr = OP_SUB; a_req_srcA = 32'd10;   a_req_srcB = 32'd3;
    b_req_valid = 1'b1; b_req_ctr = OP_XOR; b_req_srcA = 32'hF0;   b_req_srcB = 32'hFF;
    a_resp_ready = 1'b1; b_resp_ready = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      automatic logic exp_b = (i % 2) == 1;
      chk($sformatf("t2_a_ready_%0d", i), 32'(a_req_ready), 32'(!exp_b));
      chk($sformatf("t2_b_ready_%0d", i), 32'(b_req_ready), 32'(exp_b));
      step(); step(); step();
      chk($sformatf("t2_a_valid_%0d", i), 32'(a_resp_valid), 32'(!exp_b));
      chk($sformatf("t2_b_valid_%0d", i), 32'(b_resp_valid), 32'(exp_b));
      chk($sformatf("t2_data_%0d", i), exp_b ? b_resp_data : a_resp_data, exp_b ? 32'h0F : 32'd7);
      step();
      chk($sformatf("t2_ops_%0d", i), 32'(ops_done), 32'((i + 1) % 4));
    end

    // Backpressure on B with A pending
    a_req_valid = 1'b0;
    b_req_ctr = OP_OR; b_req_srcA = 32'h0F0; b_req_srcB = 32'h00F; b_resp_ready = 1'b0;
    #1;
    chk("t3_b_ready", 32'(b_req_ready), 32'd1);
    step();
    b_req_valid = 1'b0;
    step(); step();
    a_req_valid = 1'b1; a_req_ctr = OP_SLT; a_req_srcA = 32'hFFFF_FFFF; a_req_srcB = 32'd1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("t3_b_valid_%0d", k), 32'(b_resp_valid), 32'd1);
      chk($sformatf("t3_b_data_%0d", k), b_resp_data, 32'hFF);
      chk($sformatf("t3_a_blocked_%0d", k), 32'(a_req_ready), 32'd0);
      step();
    end
    b_resp_ready = 1'b1;
    step();
    chk("t3_b_done", 32'(b_resp_valid), 32'd0);
    chk("t3_ops", 32'(ops_done), 32'd1);
    chk("t3_a_ready", 32'(a_req_ready), 32'd1);

    // Payload isolation: SLT -1 < 1
    step();
    a_req_valid = 1'b0;
    chk("t4_ctr_issue", 32'(alu_ctr), 32'(OP_SLT));
    chk("t4_srcA_issue", alu_srcA, 32'hFFFF_FFFF);
    step();
    chk("t4_ctr_wait", 32'(alu_ctr), 32'(OP_SLT));
    chk("t4_srcA_wait", alu_srcA, 32'hFFFF_FFFF);
    chk("t4_srcB_wait", alu_srcB, 32'd1);
    step();
    chk("t4_a_valid", 32'(a_resp_valid), 32'd1);
    chk("t4_a_data", a_resp_data, 32'd1);
    chk("t4_b_valid", 32'(b_resp_valid), 32'd0);
    step();
    chk("t4_ops", 32'(ops_done), 32'd2);

    // Reset during WAIT
    a_req_valid = 1'b1; a_req_ctr = OP_ADD; a_req_srcA = 32'd100; a_req_srcB = 32'd200;
    step();
    a_req_valid = 1'b0;
    step();
    resetn = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_ops", 32'(ops_done), 32'd0);
    chk("t5_alu_ctr", 32'(alu_ctr), 32'd0);
    chk("t5_alu_srcA", alu_srcA, 32'd0);
    step(); step();
    chk("t5_a_resp_valid", 32'(a_resp_valid), 32'd0);
    chk("t5_b_resp_valid", 32'(b_resp_valid), 32'd0);
    resetn = 1'b1;
    a_req_valid = 1'b1;
    b_req_valid = 1'b1;
    #1;
    chk("t5_a_wins", 32'(a_req_ready), 32'd1);
    chk("t5_b_waits", 32'(b_req_ready), 32'd0);
    step();
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    step(); step();
    chk("t5_a_data", a_resp_data, 32'd300);
    step();
    chk("t5_ops_after", 32'(ops_done), 32'd1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
